// File: rtl/mining_pkg.sv
// Shared constants, state encoding and block-2 assembly helper for the nonce scan controller.
package mining_pkg;

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned CYCLE_W = 6;
    localparam int unsigned HASH_W  = 256;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TAIL_W  = 96;
    localparam int unsigned BLOCK_W = 512;

    localparam logic [CYCLE_W-1:0] CYCLE_LAST   = 6'd63;
    localparam logic [WORD_W-1:0]  PAD_WORD     = 32'h8000_0000;
    localparam logic [WORD_W-1:0]  LEN_WORD_HDR = 32'h0000_0280;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} scan_state_e;

    // Header tail as carried on the host bus: bits, time, merkle tail (LSB word).
    typedef struct packed {
        logic [WORD_W-1:0] bits;
        logic [WORD_W-1:0] ntime;
        logic [WORD_W-1:0] merkle;
    } hdr_tail_t;

    function automatic logic [BLOCK_W-1:0] build_w(input hdr_tail_t tail, input logic [NONCE_W-1:0] nonce);
        logic [BLOCK_W-1:0] w;
        w          = '0;
        w[95:0]    = tail;
        w[127:96]  = nonce;
        w[159:128] = PAD_WORD;
        w[511:480] = LEN_WORD_HDR;
        return w;
    endfunction

endpackage

// File: rtl/nonce_scan_ctrl_if.sv
// Host-side work/result signals and sha256-core signals of the nonce scan controller.
interface nonce_scan_ctrl_if;
    import mining_pkg::*;

    logic                 start;
    logic                 abort;
    logic [HASH_W-1:0]    midstate;
    logic [TAIL_W-1:0]    header_tail;
    logic [HASH_W-1:0]    target;
    logic [NONCE_W-1:0]   nonce_start;
    logic [NONCE_W-1:0]   nonce_end;
    logic [HASH_W-1:0]    H;
    logic [BLOCK_W-1:0]   W;
    logic [CYCLE_W-1:0]   cycle;
    logic [HASH_W-1:0]    hash;
    logic                 busy;
    logic                 found;
    logic [NONCE_W-1:0]   found_nonce;
    logic                 done;

    modport slave (
        input  start, abort, midstate, header_tail, target, nonce_start, nonce_end, hash,
        output H, W, cycle, busy, found, found_nonce, done
    );

    modport master (
        output start, abort, midstate, header_tail, target, nonce_start, nonce_end, hash,
        input  H, W, cycle, busy, found, found_nonce, done
    );

endinterface

// File: rtl/target_compare.sv
// Unsigned 256-bit hash <= target check, kept separate so it can be timed on its own.
module target_compare
    import mining_pkg::*;
(
    input  logic [HASH_W-1:0] hash_i,
    input  logic [HASH_W-1:0] target_i,
    output logic              hit_c_o
);

    assign hit_c_o = (hash_i <= target_i);

endmodule

// File: rtl/nonce_scan_ctrl.sv
// Nonce scan controller: feeds midstate/nonce work to the sha256 core and reports target hits.
// Define NONCE_SCAN_STOP_ON_FOUND_EN to end the scan at the first hit.
module nonce_scan_ctrl
    import mining_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    nonce_scan_ctrl_if.slave bus
);

    scan_state_e        state_q, state_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] chk_nonce_q, chk_nonce_d;
    logic               chk_valid_q, chk_valid_d;
    logic [HASH_W-1:0]  midstate_q, midstate_d;
    hdr_tail_t          tail_q, tail_d;
    logic [HASH_W-1:0]  target_q, target_d;
    logic               found_q, found_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic scanning_c, cyc_zero_c, hit_c, hit_now_c, stop_hit_c;

    target_compare u_cmp (
        .hash_i   (bus.hash),
        .target_i (target_q),
        .hit_c_o  (hit_c)
    );

    assign scanning_c = (state_q == RUN) || (state_q == DRAIN);
    assign cyc_zero_c = (cycle_q == '0);
    // The core's hash is only meaningful on the rollover clock of a launched nonce.
    assign hit_now_c  = scanning_c && cyc_zero_c && chk_valid_q && hit_c && !bus.abort;

`ifdef NONCE_SCAN_STOP_ON_FOUND_EN
    assign stop_hit_c = hit_now_c;
`else
    assign stop_hit_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.start) state_d = RUN;
            RUN: begin
                if (bus.abort)                                  state_d = IDLE;
                else if (stop_hit_c)                            state_d = DONE;
                else if (cyc_zero_c && nonce_q == bus.nonce_end) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.abort)      state_d = IDLE;
                else if (cyc_zero_c) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cycle_d       = '0;
        nonce_d       = nonce_q;
        chk_nonce_d   = chk_nonce_q;
        chk_valid_d   = chk_valid_q;
        midstate_d    = midstate_q;
        tail_d        = tail_q;
        target_d      = target_q;
        found_d       = 1'b0;
        found_nonce_d = found_nonce_q;
        done_d        = (state_d == DONE);
        busy_d        = (state_d == RUN) || (state_d == DRAIN);

        if (state_q == IDLE && bus.start) begin
            midstate_d  = bus.midstate;
            tail_d      = hdr_tail_t'(bus.header_tail);
            target_d    = bus.target;
            nonce_d     = bus.nonce_start;
            chk_valid_d = 1'b0;
        end

        if (state_q == RUN && !bus.abort && cyc_zero_c) begin
            chk_nonce_d = nonce_q;
            chk_valid_d = 1'b1;
            if (nonce_q != bus.nonce_end) nonce_d = nonce_q + NONCE_W'(1);
        end

        if (scanning_c && busy_d)
            cycle_d = (cycle_q == CYCLE_LAST) ? '0 : cycle_q + CYCLE_W'(1);

        if (hit_now_c) begin
            found_d       = 1'b1;
            found_nonce_d = chk_nonce_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q       <= '0;
            nonce_q       <= '0;
            chk_nonce_q   <= '0;
            chk_valid_q   <= 1'b0;
            midstate_q    <= '0;
            tail_q        <= '0;
            target_q      <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cycle_q       <= cycle_d;
            nonce_q       <= nonce_d;
            chk_nonce_q   <= chk_nonce_d;
            chk_valid_q   <= chk_valid_d;
            midstate_q    <= midstate_d;
            tail_q        <= tail_d;
            target_q      <= target_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.H           = midstate_q;
    assign bus.W           = build_w(tail_q, nonce_q);
    assign bus.cycle       = cycle_q;
    assign bus.busy        = busy_q;
    assign bus.found       = found_q;
    assign bus.found_nonce = found_nonce_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_nonce_scan_ctrl.sv
// Bench for nonce_scan_ctrl with a stand-in hash core; honours NONCE_SCAN_STOP_ON_FOUND_EN.
module tb_nonce_scan_ctrl;

    typedef struct {
        logic [31:0] nonce;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cnt = 0;
    int   c0 = 0;
    int   exp_done = -1;
    int   busy_cnt = 0;
    bit   done_seen = 1'b0;
    exp_t exp_q[$];
    logic [31:0] core_nonce = 32'd0;

    nonce_scan_ctrl_if bus ();

    nonce_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    // Stand-in core: even nonces have a large MSB word, odd nonces are small.
    function automatic logic [255:0] hash_of(input logic [31:0] n);
        return {(n[0] ? 32'd0 : 32'd1), 192'd0, n};
    endfunction

    function automatic logic [511:0] exp_w(input logic [95:0] tail, input logic [31:0] n);
        return {32'h0000_0280, 320'd0, 32'h8000_0000, n, tail};
    endfunction

    always @(posedge clk) if (bus.cycle == 6'd0) core_nonce <= bus.W[127:96];
    assign bus.hash = hash_of(core_nonce);

    // Scoreboard: found pulses and done timing against expectations pushed at launch.
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.found === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL found_unexpected: nonce %h at clock %0d, none expected", bus.found_nonce, cnt - c0);
            end else begin
                e = exp_q.pop_front();
                if (bus.found_nonce !== e.nonce || cnt != e.at) begin
                    errors++;
                    $display("FAIL found_event: nonce %h at clock %0d, expected nonce %h at clock %0d",
                             bus.found_nonce, cnt - c0, e.nonce, e.at - c0);
                end
            end
        end
        if (bus.done === 1'b1 || cnt == exp_done) begin
            checks++;
            if (bus.done !== 1'b1 || cnt != exp_done) begin
                errors++;
                $display("FAIL done_timing: done=%b at clock %0d, expected done at clock %0d", bus.done, cnt - c0, exp_done - c0);
            end
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
    end

    task automatic launch(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt);
        logic [31:0] span;
        logic [31:0] n;
        int          count;
        exp_t        e;
        @(negedge clk);
        bus.nonce_start = ns;
        bus.nonce_end   = ne;
        bus.target      = tgt;
        bus.midstate    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        bus.header_tail = {$urandom(), $urandom(), $urandom()};
        bus.start       = 1'b1;
        busy_cnt        = 0;
        done_seen       = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        c0        = cnt;
        span      = ne - ns;
        count     = int'(span) + 1;
        exp_done  = c0 + 1 + 64 * count;
        for (int k = 0; k < count; k++) begin
            n = ns + 32'(k);
            if (hash_of(n) <= tgt) begin
                e.nonce = n;
                e.at    = c0 + 65 + 64 * k;
                exp_q.push_back(e);
`ifdef NONCE_SCAN_STOP_ON_FOUND_EN
                exp_done = e.at;
                break;
`endif
            end
        end
    endtask

    task automatic test_reset();
        bit bad;
        launch(32'd0, 32'd3, '1);
        while (cnt < c0 + 30) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_done = -1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.H !== 256'd0) begin errors++; $display("FAIL reset_H: got %h expected 0", bus.H); end
        checks++;
        if (bus.W !== exp_w(96'd0, 32'd0)) begin errors++; $display("FAIL reset_W: got %h expected %h", bus.W, exp_w(96'd0, 32'd0)); end
        checks++;
        if ({bus.cycle, bus.busy, bus.found, bus.done} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: cycle=%0d busy=%b found=%b done=%b expected all 0", bus.cycle, bus.busy, bus.found, bus.done);
        end
        checks++;
        if (bus.found_nonce !== 32'd0) begin errors++; $display("FAIL reset_found_nonce: got %h expected 0", bus.found_nonce); end
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.cycle !== 6'd0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL reset_idle_hold: cycle/busy moved after reset, last cycle=%0d busy=%b", bus.cycle, bus.busy); end
    endtask

    task automatic test_single();
        logic [95:0] tail;
        launch(32'h7C2B_AC1D, 32'h7C2B_AC1D, '1);
        tail = bus.header_tail;
        checks++;
        if (bus.H !== bus.midstate) begin errors++; $display("FAIL single_H: got %h expected %h", bus.H, bus.midstate); end
        @(negedge clk);
        checks++;
        if (bus.cycle !== 6'd1) begin errors++; $display("FAIL single_cycle_after_launch: got %0d expected 1", bus.cycle); end
        checks++;
        if (bus.W !== exp_w(tail, 32'h7C2B_AC1D)) begin
            errors++;
            $display("FAIL single_W: got %h expected %h", bus.W, exp_w(tail, 32'h7C2B_AC1D));
        end
        for (int i = 0; i < 200 && !done_seen; i++) @(negedge clk);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL single_timeout: done=0 expected done within 200 clocks"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing_found: %0d left expected 0", exp_q.size()); end
        @(negedge clk);
        checks++;
        if (bus.found_nonce !== 32'h7C2B_AC1D) begin errors++; $display("FAIL single_found_hold: got %h expected 7c2bac1d", bus.found_nonce); end
    endtask

    task automatic test_no_hits();
        launch(32'd0, 32'd3, '0);
        while (cnt < c0 + 50) @(negedge clk);
        bus.nonce_start = 32'd100;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.nonce_start = 32'd0;
        for (int i = 0; i < 400 && !done_seen; i++) @(negedge clk);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL nohit_timeout: done=0 expected done within 400 clocks"); end
        checks++;
        if (busy_cnt != 257) begin errors++; $display("FAIL nohit_busy_len: got %0d expected 257", busy_cnt); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL nohit_busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_wrap();
        logic [31:0] last;
`ifdef NONCE_SCAN_STOP_ON_FOUND_EN
        last = 32'hFFFF_FFFE;
`else
        last = 32'd1;
`endif
        launch(32'hFFFF_FFFE, 32'd1, '1);
        for (int i = 0; i < 400 && !done_seen; i++) @(negedge clk);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL wrap_timeout: done=0 expected done within 400 clocks"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing_found: %0d left expected 0", exp_q.size()); end
        checks++;
        if (bus.found_nonce !== last) begin errors++; $display("FAIL wrap_last_nonce: got %h expected %h", bus.found_nonce, last); end
    endtask

    task automatic test_mixed();
        launch(32'd4, 32'd7, {32'd0, 192'd0, 32'd5});
        for (int i = 0; i < 400 && !done_seen; i++) @(negedge clk);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL mixed_timeout: done=0 expected done within 400 clocks"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mixed_missing_found: %0d left expected 0", exp_q.size()); end
        checks++;
        if (bus.found_nonce !== 32'd5) begin errors++; $display("FAIL mixed_found_nonce: got %h expected 5", bus.found_nonce); end
    endtask

`ifdef NONCE_SCAN_STOP_ON_FOUND_EN
    task automatic test_stop_on_found();
        launch(32'd10, 32'd20, '1);
        for (int i = 0; i < 200 && !done_seen; i++) @(negedge clk);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL stop_timeout: done=0 expected done within 200 clocks"); end
        checks++;
        if (bus.found_nonce !== 32'd10) begin errors++; $display("FAIL stop_found_nonce: got %h expected a", bus.found_nonce); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_busy_after: got %b expected 0", bus.busy); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stop_missing_found: %0d left expected 0", exp_q.size()); end
    endtask
`endif

    task automatic test_abort();
        launch(32'd0, 32'd9, '0);
        while (cnt < c0 + 99) @(negedge clk);
        bus.abort = 1'b1;
        exp_done  = -1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.cycle !== 6'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b cycle=%0d done=%b expected 0/0/0", bus.busy, bus.cycle, bus.done);
        end
        @(negedge clk);
        launch(32'd0, 32'd2, '1);
        checks++;
        if (bus.W[127:96] !== 32'd0) begin errors++; $display("FAIL abort_relaunch_nonce: got %h expected 0", bus.W[127:96]); end
        for (int i = 0; i < 300 && !done_seen; i++) @(negedge clk);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL abort_relaunch_timeout: done=0 expected done within 300 clocks"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL abort_missing_found: %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.midstate    = '0;
        bus.header_tail = '0;
        bus.target      = '0;
        bus.nonce_start = '0;
        bus.nonce_end   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single();
        test_no_hits();
        test_wrap();
        test_mixed();
`ifdef NONCE_SCAN_STOP_ON_FOUND_EN
        test_stop_on_found();
`endif
        test_abort();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_scan_ctrl.md
# nonce_scan_ctrl

Work controller that sits directly upstream of the `sha256` double-hash core. It drives `H` (midstate), `W` (second header chunk with the nonce inserted) and the 6-bit `cycle` count. It samples the core's `hash` at every `cycle` rollover and compares it against a target. The core returns one nonce result every 64 clocks, and this block reports hits back to the host/UART side.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin scan; sampled only in IDLE.
- `abort` in 1: stop scan; goes to IDLE next clock with no `done`.
- `midstate` in 256: SHA-256 state after chunk 1; word i is `[32i+31:32i]`.
- `header_tail` in 96: merkle tail (`[31:0]`), time (`[63:32]`), bits (`[95:64]`).
- `target` in 256: hit when `hash <= target` (unsigned, `hash[255:224]` most significant).
- `nonce_start` in 32: first nonce.
- `nonce_end` in 32: last nonce, inclusive.
- `H` out 256: to core; the registered copy of `midstate`.
- `W` out 512: to core; word i is `[32i+31:32i]`.
- `cycle` out 6: to core.
- `hash` in 256: from core; valid combinationally while `cycle == 0`.
- `busy` out 1: high in RUN or DRAIN.
- `found` out 1: one-clock pulse per hit.
- `found_nonce` out 32: nonce of the most recent hit; held until the next hit or reset.
- `done` out 1: one-clock pulse at scan completion.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `cycle` is held at 0.
  - On `start`: latch `midstate`, `header_tail` and `target`; set `nonce <= nonce_start`, `chk_valid <= 0`, `cycle <= 0`; go to RUN.
- **RUN**
  - `cycle <= cycle + 1` every clock, wrapping 63 -> 0.
  - On each edge where `cycle == 0`: `chk_nonce <= nonce`, `chk_valid <= 1`.
  - If `nonce == nonce_end`, go to DRAIN. Otherwise `nonce <= nonce + 1` (mod 2^32).
- **DRAIN**
  - `cycle` keeps counting.
  - At the next `cycle == 0` edge, evaluate the last result, then go to DONE.
- **DONE**
  - `done = 1` for one clock, then IDLE.
- **W assembly**
  - Words 0–2: `header_tail`.
  - Word 3: `nonce`.
  - Word 4: `32'h80000000`.
  - Words 5–14: 0.
  - Word 15: `32'h00000280`.
- **Compare**
  - During any clock with `cycle == 0`, `chk_valid == 1` and state RUN or DRAIN: if `hash <= target`, then at that edge set `found <= 1` and `found_nonce <= chk_nonce`.
  - `chk_nonce` at that moment is the nonce launched 64 clocks earlier.
- **Wrap-around:** `nonce_end < nonce_start` scans through `0xFFFFFFFF` to 0. `nonce_start == nonce_end` scans exactly one nonce.
- **Priority:** `rst` > `abort` > normal. `start` while busy is ignored.
- **`abort` in DRAIN:** no compare and no `done`.

## Timing
- **Reset values:** `cycle=0`, `busy=0`, `found=0`, `found_nonce=0`, `done=0`, `H=0`, `W` built from zeroed latches, state IDLE.
- **Launch:** `start` sampled at edge E0. The first nonce is loaded into the core at edge E1 (`cycle == 0`). `cycle` reads 1 after E1.
- **Latency:** nonce launched at edge E is checked at edge E+64; `found` is high in the clock after E+64.
- **Throughput:** 1 nonce per 64 clocks.
- **Total scan:** N nonces take `1 + 64*N` clocks from `start` to DONE. `done` is high during clock `1 + 64*N + 1`.
- **Last-hit ordering:** a hit on the last nonce pulses `found` in the same clock that `done` is high.
- **Reset mid-scan:** next clock equals the reset state; no `found` or `done` is issued.

## Configuration
- `NONCE_SCAN_STOP_ON_FOUND_EN`
  - **Defined:** a hit moves RUN/DRAIN straight to DONE at the same edge. `found` and `done` pulse together; remaining nonces are not scanned.
  - **Undefined:** the scan always runs to `nonce_end`. Every hit pulses `found`, and `found_nonce` holds the last hit.

## Structure
- Package `mining_pkg` holds:
  - the state enum;
  - `PAD_WORD = 32'h80000000`;
  - `LEN_WORD_HDR = 32'h00000280`;
  - `NONCE_W = 32`, `CYCLE_W = 6`, `CYCLE_LAST = 6'd63`.
- One sub-module, `target_compare`: combinational 256-bit `hash <= target` check, isolated for timing.
- The block instantiates nothing else; the `sha256` core is instantiated alongside it at the top level.

## Test plan
- **Reset:** `rst` held 3 clocks during RUN → all outputs at reset values; `cycle` stays 0 and no pulses follow.
- **Single nonce:** `nonce_start = nonce_end = 0x7C2BAC1D`, `target` = all ones → `found` at clock 66 after `start` with `found_nonce = 0x7C2BAC1D`; `done` in the same clock; `W` word 3 = `0x7C2BAC1D`, word 15 = `0x280`.
- **No hits:** `target = 0`, range 0..3 → no `found`; `done` exactly 258 clocks after `start`; `busy` high for 257 clocks.
- **Wrap:** `nonce_start = 0xFFFFFFFE`, `nonce_end = 1`, target all ones, macro undefined → four `found` pulses, 64 clocks apart, with nonces FFFFFFFE, FFFFFFFF, 0, 1.
- **Stop on found:** macro defined, target all ones, range 10..20 → single `found` with nonce 10; `done` in the same clock; `busy` low next clock.
- **Abort:** `abort` at clock 100 of a 0..9 scan → IDLE next clock; no `found` or `done`; a new `start` 2 clocks later relaunches cleanly from `nonce_start`.
